// File: rtl/div_hilo_seq_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM state encoding,
// result/start flag values, bus width and iteration count.
package div_hilo_seq_pkg;

    localparam int REG_BUS_W = 32;
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // One restoring iteration per quotient bit.
    localparam int DIV_ITERATIONS = REG_BUS_W;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_hilo_seq_div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps the difference when it is non-negative.
module div_step
    import div_hilo_seq_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              dvd_msb_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_bit_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // The partial remainder is always below the divisor, so DATA_W+1 bits
    // suffice: the top bit of the difference is a clean sign bit.
    assign shifted = {rem_i, dvd_msb_i};
    assign trial   = shifted - {1'b0, divisor_i};

    // Restore (keep shifted value) or accept the trial difference.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
        rem_o   = shifted[DATA_W-1:0];
        q_bit_o = 1'b0;
        if (!trial[DATA_W]) begin
            rem_o   = trial[DATA_W-1:0];
            q_bit_o = 1'b1;
        end
    end

endmodule

// File: rtl/div_hilo_seq.sv
// div_hilo_seq: multi-cycle signed/unsigned divider for the EX stage.
// Writes HI (remainder) and LO (quotient) with a one-cycle hilo_we_o pulse.
// Optional build macro DIV_EARLY_EXIT_EN: finish in one cycle when
// |dividend| < |divisor|.
module div_hilo_seq
    import div_hilo_seq_pkg::*;
#(
    parameter int DATA_W = DIV_ITERATIONS,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_div_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    output logic              stallreq_o,
    output logic              ready_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvd_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [DATA_W-1:0] dvs_q;
    logic              neg_quot_q;
    logic              neg_rem_q;
    logic              ready_q;
    logic              hilo_we_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic              op1_neg;
    logic              op2_neg;
    logic [DATA_W-1:0] op1_mag;
    logic [DATA_W-1:0] op2_mag;
    logic [DATA_W-1:0] step_rem_d;
    logic              step_qbit_d;
    logic [DATA_W-1:0] quot_d;
    logic [DATA_W-1:0] quot_fix_d;
    logic [DATA_W-1:0] rem_fix_d;

    // Operand magnitudes for signed divides; unsigned operands pass through.
    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[DATA_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_d),
        .q_bit_o   (step_qbit_d)
    );

    // Sign fix-up applied as the final iteration lands in END.
    assign quot_d     = {dvd_q[DATA_W-2:0], step_qbit_d};
    assign quot_fix_d = neg_quot_q ? -quot_d : quot_d;
    assign rem_fix_d  = neg_rem_q ? -step_rem_d : step_rem_d;

    // Sequencer FSM with registered result outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every branch sees the pre-edge values, as real flops do.
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= DIV_RESULT_NOT_READY;
            hilo_we_q  <= 1'b0;
            hi_q       <= DATA_W'(ZERO_WORD);
            lo_q       <= DATA_W'(ZERO_WORD);
        end else begin
            hilo_we_q <= 1'b0;
            case (state_q)
                DivFree: begin
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= DivByZero;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (op1_mag < op2_mag) begin
                            state_q   <= DivEnd;
                            ready_q   <= DIV_RESULT_READY;
                            hilo_we_q <= 1'b1;
                            hi_q      <= opdata1_i;
                            lo_q      <= '0;
`endif
                        end else begin
                            state_q    <= DivOn;
                            cnt_q      <= '0;
                            rem_q      <= '0;
                            dvd_q      <= op1_mag;
                            dvs_q      <= op2_mag;
                            neg_quot_q <= op1_neg ^ op2_neg;
                            neg_rem_q  <= op1_neg;
                        end
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                    end else begin
                        state_q   <= DivEnd;
                        ready_q   <= DIV_RESULT_READY;
                        hilo_we_q <= 1'b1;
                        hi_q      <= '0;
                        lo_q      <= '0;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                    end else begin
                        rem_q <= step_rem_d;
                        dvd_q <= quot_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            state_q   <= DivEnd;
                            ready_q   <= DIV_RESULT_READY;
                            hilo_we_q <= 1'b1;
                            hi_q      <= rem_fix_d;
                            lo_q      <= quot_fix_d;
                        end
                    end
                end
                DivEnd: begin
                    if (annul_i || start_i == DIV_STOP) begin
                        state_q <= DivFree;
                        ready_q <= DIV_RESULT_NOT_READY;
                        hi_q    <= '0;
                        lo_q    <= '0;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    // Stall EX until the result is on the outputs; annul kills both stall and write.
    assign stallreq_o = start_i & ~annul_i & (state_q != DivEnd);
    assign hilo_we_o  = hilo_we_q & ~annul_i;
    assign ready_o    = ready_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_div_hilo_seq.sv
// Self-checking bench for div_hilo_seq: directed cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div_hilo_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        stallreq_o;
    logic        ready_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    div_hilo_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .stallreq_o   (stallreq_o),
        .ready_o      (ready_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference quotient/remainder from plain integer arithmetic.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic longint mag(input bit sgn, input logic [31:0] v);
        longint s;
        if (sgn) begin
            s = longint'($signed(v));
            return (s < 0) ? -s : s;
        end
        return longint'({32'd0, v});
    endfunction

    // Cycle (start cycle = 0) at which ready_o first appears.
    function automatic int ref_latency(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        if (mag(sgn, a) < mag(sgn, b)) return 1;
`else
        if (mag(sgn, a) < 0) return 0;
`endif
        return 33;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Full transaction: start held until ready, one extra END cycle, then drop.
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        int lat, seen, we_cnt, stall_bad;
        ref_div(sgn, a, b, eq, er);
        lat       = ref_latency(sgn, a, b);
        seen      = -1;
        we_cnt    = 0;
        stall_bad = 0;
        @(negedge clk);
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        #1;
        check({tag, ":stall_c0"}, {31'd0, stallreq_o}, 32'd1);
        for (int cyc = 1; cyc <= 40 && seen < 0; cyc++) begin
            @(negedge clk);
            if (hilo_we_o) we_cnt++;
            if (ready_o) seen = cyc;
            else if (!stallreq_o) stall_bad++;
            if (cyc == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
        end
        check({tag, ":end_cycle"}, seen, lat);
        if (seen < 0) begin
            do_reset();
            return;
        end
        check({tag, ":stall_busy"}, stall_bad, 32'd0);
        check({tag, ":stall_end"}, {31'd0, stallreq_o}, 32'd0);
        check({tag, ":hi"}, hi_o, er);
        check({tag, ":lo"}, lo_o, eq);
        @(negedge clk);
        if (hilo_we_o) we_cnt++;
        check({tag, ":ready_hold"}, {31'd0, ready_o}, 32'd1);
        check({tag, ":lo_hold"}, lo_o, eq);
        start_i = 1'b0;
        @(negedge clk);
        if (hilo_we_o) we_cnt++;
        check({tag, ":we_pulses"}, we_cnt, 32'd1);
        check({tag, ":ready_clr"}, {31'd0, ready_o}, 32'd0);
        check({tag, ":hi_clr"}, hi_o, 32'd0);
        check({tag, ":lo_clr"}, lo_o, 32'd0);
    endtask

    initial begin
        int we_cnt;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (2) @(negedge clk);
        check("rst:ready", {31'd0, ready_o}, 32'd0);
        check("rst:we", {31'd0, hilo_we_o}, 32'd0);
        check("rst:hi", hi_o, 32'd0);
        check("rst:lo", lo_o, 32'd0);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("div_by_zero", 1'b1, 32'd1234, 32'd0);
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10);
        run_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10);

        // Annul during ON: back to FREE, no write ever.
        we_cnt = 0;
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul:stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_we_o) we_cnt++;
            check("annul:ready", {31'd0, ready_o}, 32'd0);
            @(negedge clk);
        end
        check("annul:we_pulses", we_cnt, 32'd0);

        // Annul in the first END cycle suppresses the write.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        repeat (2) @(negedge clk);
        check("annul_end:ready", {31'd0, ready_o}, 32'd1);
        annul_i = 1'b1;
        #1;
        check("annul_end:we", {31'd0, hilo_we_o}, 32'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_end:free", {31'd0, ready_o}, 32'd0);

        // Reset mid-divide, then a fresh divide.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'h1234_5678;
        opdata2_i = 32'h11;
        repeat (20) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("rst_mid:ready", {31'd0, ready_o}, 32'd0);
        check("rst_mid:we", {31'd0, hilo_we_o}, 32'd0);
        check("rst_mid:hi", hi_o, 32'd0);
        check("rst_mid:lo", lo_o, 32'd0);
        check("rst_mid:stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // Randomized divides across divisor classes.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            bit sgn;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(8, 31);
            run_div($sformatf("rnd%0d", n), sgn, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
